// File: rtl/wb_arbiter.sv
// Writeback arbiter for the RV64I pipeline.
// Drives the single register-file write port from two sources: ALU results,
// which win whenever present, and load responses, which are aligned and
// extended on entry and then parked in a small FIFO until the port is free.
// A starvation counter raises alu_stall so parked loads always drain.
//
// Handshake: a load response transfers on a rising edge where
// mem_rsp_valid && mem_rsp_ready. mem_rsp_ready is !full only. A dequeue in
// the same cycle does not open a slot for the incoming response.
`timescale 1ns/1ps
module wb_arbiter #(
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_rd,
  input  logic [63:0]                 alu_data,
  output logic                        alu_stall,
  input  logic                        mem_rsp_valid,
  output logic                        mem_rsp_ready,
  input  logic [4:0]                  mem_rsp_rd,
  input  logic [63:0]                 mem_rsp_data,
  input  logic [2:0]                  mem_rsp_funct3,
  input  logic [2:0]                  mem_rsp_offset,
  output logic                        wb_en,
  output logic [4:0]                  wb_rd,
  output logic [63:0]                 wb_data,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [AW:0]   DEPTH_C  = LQ_DEPTH;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [SW-1:0] LIMIT_C  = STARVE_LIMIT;
  localparam logic [SW-1:0] STV_ONE  = 1;

  // Load queue storage (no reset needed: contents are qualified by count)
  logic [63:0]   lq_data_q [LQ_DEPTH];
  logic [4:0]    lq_rd_q   [LQ_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          alu_stall_q, alu_stall_d;
  logic          wb_en_q, wb_en_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [63:0]   wb_data_q, wb_data_d;

  logic          empty, full, enq, deq;
  logic [63:0]   ext_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_word;
  logic [63:0]   head_data;
  logic [4:0]    head_rd;

  // Select the addressed byte/half/word and sign- or zero-extend it
  always_comb begin
    ld_byte  = 8'(mem_rsp_data >> {mem_rsp_offset, 3'b000});
    ld_half  = 16'(mem_rsp_data >> {mem_rsp_offset[2:1], 4'b0000});
    ld_word  = 32'(mem_rsp_data >> {mem_rsp_offset[2], 5'b00000});
    ext_data = '0;
    case (mem_rsp_funct3)
      3'b000:  ext_data = {{56{ld_byte[7]}}, ld_byte};
      3'b001:  ext_data = {{48{ld_half[15]}}, ld_half};
      3'b010:  ext_data = {{32{ld_word[31]}}, ld_word};
      3'b011:  ext_data = mem_rsp_data;
      3'b100:  ext_data = {56'd0, ld_byte};
      3'b101:  ext_data = {48'd0, ld_half};
      3'b110:  ext_data = {32'd0, ld_word};
      default: ext_data = '0;
    endcase
  end

  // Arbitration, queue bookkeeping and starvation tracking
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == DEPTH_C);
    enq       = mem_rsp_valid && !full;
    deq       = !alu_valid && !empty;
    head_data = lq_data_q[rd_ptr_q];
    head_rd   = lq_rd_q[rd_ptr_q];

    wr_ptr_d  = enq ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = deq ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d   = count_q;
    if (enq && !deq) begin
      count_d = count_q + CNT_ONE;
    end else if (!enq && deq) begin
      count_d = count_q - CNT_ONE;
    end

    wb_en_d   = 1'b0;
    wb_rd_d   = '0;
    wb_data_d = '0;
    if (alu_valid) begin
      wb_en_d   = (alu_rd != 5'd0);
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end else if (!empty) begin
      wb_en_d   = (head_rd != 5'd0);
      wb_rd_d   = head_rd;
      wb_data_d = head_data;
    end

    // Non-empty and not dequeuing means the ALU just beat the head
    if (empty || deq) begin
      starve_d = '0;
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + STV_ONE;
    end else begin
      starve_d = starve_q;
    end
    alu_stall_d = (starve_d == LIMIT_C);
  end

  // Queue entry write on accepted response
  always_ff @(posedge clk) begin
    if (enq) begin
      lq_data_q[wr_ptr_q] <= ext_data;
      lq_rd_q[wr_ptr_q]   <= mem_rsp_rd;
    end
  end

  // Control and writeback registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign alu_stall     = alu_stall_q;
  assign mem_rsp_ready = !full;
  assign wb_en         = wb_en_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign lq_count      = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU path, load extraction, FIFO fill and
// starvation stall, rd=0 suppression and asynchronous reset mid-burst.
`timescale 1ns/1ps
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_stall;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [4:0]  mem_rsp_rd;
  logic [63:0] mem_rsp_data;
  logic [2:0]  mem_rsp_funct3;
  logic [2:0]  mem_rsp_offset;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [1:0]  lq_count;

  int checks;
  int failures;

  wb_arbiter #(.LQ_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_stall      (alu_stall),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_ready  (mem_rsp_ready),
    .mem_rsp_rd     (mem_rsp_rd),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_funct3 (mem_rsp_funct3),
    .mem_rsp_offset (mem_rsp_offset),
    .wb_en          (wb_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .lq_count       (lq_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load into an idle arbiter: accepted at edge N, written at edge N+1
  task automatic load_one(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [2:0] off, input logic [63:0] data,
                          input logic [63:0] exp);
    mem_rsp_valid  = 1'b1;
    mem_rsp_rd     = rd;
    mem_rsp_funct3 = f3;
    mem_rsp_offset = off;
    mem_rsp_data   = data;
    step();
    check({tag, "_acc_count"}, lq_count, 64'd1);
    check({tag, "_acc_wben"}, wb_en, 64'd0);
    mem_rsp_valid = 1'b0;
    step();
    check({tag, "_wben"}, wb_en, 64'd1);
    check({tag, "_rd"}, wb_rd, rd);
    check({tag, "_data"}, wb_data, exp);
    check({tag, "_count"}, lq_count, 64'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    alu_valid      = 1'b0;
    alu_rd         = '0;
    alu_data       = '0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_rd     = '0;
    mem_rsp_data   = '0;
    mem_rsp_funct3 = '0;
    mem_rsp_offset = '0;

    // Reset state
    step();
    step();
    check("rst_wben", wb_en, 64'd0);
    check("rst_wbrd", wb_rd, 64'd0);
    check("rst_wbdata", wb_data, 64'd0);
    check("rst_stall", alu_stall, 64'd0);
    check("rst_count", lq_count, 64'd0);
    check("rst_ready", mem_rsp_ready, 64'd1);
    rst = 1'b0;
    step();

    // ALU single-cycle path
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 64'h1234;
    step();
    check("alu_wben", wb_en, 64'd1);
    check("alu_rd", wb_rd, 64'd5);
    check("alu_data", wb_data, 64'h1234);
    alu_valid = 1'b0;
    step();
    check("alu_idle_wben", wb_en, 64'd0);

    // Load extraction
    load_one("lb",   5'd3, 3'b000, 3'd3, 64'h00000000_80FF7F00, 64'hFFFFFFFF_FFFFFF80);
    load_one("lbu",  5'd3, 3'b100, 3'd3, 64'h00000000_80FF7F00, 64'h00000000_00000080);
    load_one("lwu",  5'd4, 3'b110, 3'd4, 64'hDEADBEEF_00000000, 64'h00000000_DEADBEEF);
    load_one("lh",   5'd6, 3'b001, 3'd6, 64'h8001_0000_0000_0000, 64'hFFFFFFFF_FFFF8001);
    load_one("lhu",  5'd8, 3'b101, 3'd3, 64'h00000000_BEEF0000, 64'h00000000_0000BEEF);
    load_one("lw",   5'd9, 3'b010, 3'd1, 64'h00000000_80000000, 64'hFFFFFFFF_80000000);
    load_one("ld",   5'd1, 3'b011, 3'd5, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);
    load_one("f111", 5'd2, 3'b111, 3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'd0);

    // Fill the queue under continuous ALU traffic, then starve the head
    alu_valid      = 1'b1;
    alu_rd         = 5'd7;
    alu_data       = 64'hA1;
    mem_rsp_valid  = 1'b1;
    mem_rsp_rd     = 5'd10;
    mem_rsp_funct3 = 3'b011;
    mem_rsp_offset = 3'd0;
    mem_rsp_data   = 64'h1111;
    step();
    check("fill1_count", lq_count, 64'd1);
    check("fill1_rd", wb_rd, 64'd7);
    check("fill1_data", wb_data, 64'hA1);
    check("fill1_stall", alu_stall, 64'd0);
    mem_rsp_rd   = 5'd11;
    mem_rsp_data = 64'h2222;
    alu_data     = 64'hA2;
    step();
    check("fill2_count", lq_count, 64'd2);
    check("fill2_ready", mem_rsp_ready, 64'd0);
    check("fill2_stall", alu_stall, 64'd0);
    check("fill2_data", wb_data, 64'hA2);
    mem_rsp_rd   = 5'd12;
    mem_rsp_data = 64'h3333;
    alu_data     = 64'hA3;
    step();
    check("lose2_stall", alu_stall, 64'd0);
    check("lose2_count", lq_count, 64'd2);
    alu_data = 64'hA4;
    step();
    check("lose3_stall", alu_stall, 64'd0);
    alu_data = 64'hA5;
    step();
    check("lose4_stall", alu_stall, 64'd1);
    check("lose4_data", wb_data, 64'hA5);
    alu_data = 64'hA6;
    step();
    check("viol_wben", wb_en, 64'd1);
    check("viol_data", wb_data, 64'hA6);
    check("viol_stall", alu_stall, 64'd1);
    check("viol_count", lq_count, 64'd2);
    alu_valid = 1'b0;
    step();
    check("drain1_rd", wb_rd, 64'd10);
    check("drain1_data", wb_data, 64'h1111);
    check("drain1_stall", alu_stall, 64'd0);
    check("drain1_count", lq_count, 64'd1);
    check("drain1_ready", mem_rsp_ready, 64'd1);
    step();
    check("drain2_rd", wb_rd, 64'd11);
    check("drain2_data", wb_data, 64'h2222);
    check("drain2_count", lq_count, 64'd1);
    mem_rsp_valid = 1'b0;
    step();
    check("drain3_rd", wb_rd, 64'd12);
    check("drain3_data", wb_data, 64'h3333);
    check("drain3_count", lq_count, 64'd0);
    step();
    check("drain_idle_wben", wb_en, 64'd0);

    // rd=0 results are consumed but never written
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 64'hFF;
    step();
    check("alu_rd0_wben", wb_en, 64'd0);
    alu_valid      = 1'b0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_rd     = 5'd0;
    mem_rsp_funct3 = 3'b011;
    mem_rsp_data   = 64'h55;
    step();
    check("ld_rd0_acc_count", lq_count, 64'd1);
    mem_rsp_valid = 1'b0;
    step();
    check("ld_rd0_wben", wb_en, 64'd0);
    check("ld_rd0_count", lq_count, 64'd0);

    // Asynchronous reset with a full queue
    alu_valid     = 1'b1;
    alu_rd        = 5'd9;
    alu_data      = 64'hBB;
    mem_rsp_valid = 1'b1;
    mem_rsp_rd    = 5'd20;
    mem_rsp_data  = 64'h1;
    step();
    mem_rsp_rd   = 5'd21;
    mem_rsp_data = 64'h2;
    step();
    check("burst_count", lq_count, 64'd2);
    check("burst_wben", wb_en, 64'd1);
    alu_valid     = 1'b0;
    mem_rsp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_wben", wb_en, 64'd0);
    check("arst_wbrd", wb_rd, 64'd0);
    check("arst_wbdata", wb_data, 64'd0);
    check("arst_count", lq_count, 64'd0);
    check("arst_ready", mem_rsp_ready, 64'd1);
    check("arst_stall", alu_stall, 64'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst1_wben", wb_en, 64'd0);
    check("post_rst1_count", lq_count, 64'd0);
    step();
    check("post_rst2_wben", wb_en, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage of the RV64I pipeline. Drives the register file's single write port (wb_en, wb_rd/rd_index, wb_data).
- Merges two result sources:
  - single-cycle ALU results, which have fixed priority;
  - variable-latency load responses, which are buffered in a small FIFO and byte-aligned and sign/zero-extended here.
- A starvation counter stalls the ALU path so buffered loads always drain.

Parameters:
LQ_DEPTH, 2, load-response FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose arbitration before alu_stall asserts

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  5  ALU destination register
alu_data  input  64  ALU result
alu_stall  output  1  registered; upstream must hold alu_valid=0 while high
mem_rsp_valid  input  1  load response present
mem_rsp_ready  output  1  FIFO can accept; equals !full
mem_rsp_rd  input  5  load destination register
mem_rsp_data  input  64  raw aligned doubleword from memory
mem_rsp_funct3  input  3  load type (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU)
mem_rsp_offset  input  3  byte address bits [2:0]
wb_en  output  1  registered write enable to register file
wb_rd  output  5  registered destination index
wb_data  output  64  registered write data
lq_count  output  $clog2(LQ_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, immediate): wb_en=0, wb_rd=0, wb_data=0, alu_stall=0, FIFO empty (lq_count=0, mem_rsp_ready=1), starve counter=0. Reset mid-operation discards buffered loads.
- Enqueue: a response is accepted on the rising edge where mem_rsp_valid && mem_rsp_ready. The extracted value and rd are stored.
- mem_rsp_ready depends only on full. There is no same-cycle pass-through when full, even if a dequeue happens that cycle.
- Extraction:
  - LB/LBU select byte offset[2:0].
  - LH/LHU select halfword offset[2:1]; offset[0] is ignored.
  - LW/LWU select word offset[2]; offset[1:0] are ignored.
  - LD takes all 64 bits; offset is ignored.
  - Signed types sign-extend to 64 bits; U types zero-extend.
  - funct3=111 stores data 0 but still writes.
- Arbitration, evaluated each cycle:
  - If alu_valid, the ALU result is selected.
  - Else if the FIFO is non-empty, the head is selected and dequeued at the edge.
  - Else nothing is selected.
- The selection is registered into wb_en/wb_rd/wb_data at the edge. Latency:
  - ALU: 1 cycle.
  - Load to an empty FIFO with no competing ALU: accepted at edge N, written at edge N+1, wb_en visible after N+1.
- rd=0: a selected result with rd=0 is consumed normally (FIFO dequeues), but wb_en=0 for that cycle.
- Starvation:
  - The counter increments at each edge where the FIFO is non-empty and the ALU wins.
  - It clears at any edge where the FIFO head is dequeued, or the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, alu_stall is registered high from the next edge.
  - alu_stall stays high until the edge at which the head dequeues, then falls at that edge.
- Contract violation: alu_valid=1 while alu_stall=1 is an upstream error. Behaviour is still defined: the ALU wins (no data loss) and alu_stall stays high.
- Simultaneous enqueue and dequeue at the same edge: count is unchanged. Pointers wrap modulo LQ_DEPTH.
- An enqueue into an empty FIFO cannot be selected in the same cycle.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0x1234 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1234. Cycle after with alu_valid=0 -> wb_en=0.
- Load LB, offset=3, data=0x00000000_80FF7F00 -> wb_data=0xFFFFFFFF_FFFFFF80. LBU same inputs -> 0x80. LWU, offset=4, data=0xDEADBEEF_00000000 -> 0xDEADBEEF. LH, offset=6, data=0x8001_0000_0000_0000 -> 0xFFFFFFFF_FFFF8001.
- Fill FIFO with 2 loads while alu_valid held 1 -> mem_rsp_ready=0, lq_count=2. A third response is held by the driver and not lost.
- alu_valid held 1 with FIFO non-empty -> alu_stall rises after 4 losing edges. Drop alu_valid -> head written, alu_stall falls, counter clears.
- ALU rd=0 and load rd=0 -> wb_en stays 0; FIFO count still decrements.
- Assert rst mid-burst with lq_count=2 -> outputs zero immediately, lq_count=0, mem_rsp_ready=1. No stale write after release.
